key_inject_arb: RTL and testbench
=================================

KEY_INJECT_ARB -- requirements
Module: key_inject_arb

Interface
REQ-001 Parameter HOLD_CYCLES, default 16'd50000: clk_sys cycles an injected key stays pressed.
REQ-002 Parameter GAP_CYCLES, default 16'd50000: clk_sys cycles of idle after each injected release.
REQ-003 Parameter FIFO_DEPTH, default 16: injection queue entries; must be a power of two, 2 to 64.
REQ-004 clk_sys  in  1  system clock; single clock domain.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 hk_strobe  in  1  host keyboard event strobe, one cycle.
REQ-007 hk_pressed  in  1  host event: 1 make, 0 break.
REQ-008 hk_extended  in  1  host event extended flag.
REQ-009 hk_code  in  8  host event scan code.
REQ-010 inj_wr  in  1  enqueue one injection entry this cycle.
REQ-011 inj_data  in  9  entry: [8] extended, [7:0] scan code; 9'h000 is a pause entry.
REQ-012 inj_abort  in  1  abort the current injection and flush the queue.
REQ-013 inj_full  out  1  queue full; inj_wr is ignored while high.
REQ-014 inj_busy  out  1  queue non-empty or FSM not IDLE.
REQ-015 key_strobe  out  1  merged event strobe to the matrix keyboard.
REQ-016 key_pressed  out  1  merged event make/break.
REQ-017 key_extended  out  1  merged event extended flag.
REQ-018 key_code  out  8  merged event scan code.

Function
REQ-019 All outputs are registered; the key_* fields hold their last value when key_strobe is 0.
REQ-020 A host event is forwarded with exactly 1-cycle latency and fields unchanged, in every FSM state.
REQ-021 Queue: FIFO of FIFO_DEPTH 9-bit entries; a write while full is dropped with no state change; simultaneous write and pop on a full queue is accepted.
REQ-022 FSM states: IDLE, PRESS, HOLD, RELEASE, GAP.
REQ-023 IDLE: when the queue is non-empty, pop the head into a current-entry register, then go to PRESS.
REQ-024 PRESS: emit a make event (pressed=1) for the current entry; for a pause entry, emit nothing; then go to HOLD with the counter cleared.
REQ-025 HOLD: count to HOLD_CYCLES-1, then go to RELEASE.
REQ-026 RELEASE: emit a break event (pressed=0) for the current entry, suppressed for a pause entry; then go to GAP with the counter cleared.
REQ-027 GAP: count to GAP_CYCLES-1, then go to IDLE; the next pop can occur in the cycle after.
REQ-028 Collision: if hk_strobe is forwarded in the same cycle an injected event is due, the host event wins. The FSM stays in PRESS/RELEASE and retries every cycle until the output is free; no event is lost or duplicated.
REQ-029 Counter is 16 bits; a parameter value of 0 is treated as 1.
REQ-030 inj_abort while in HOLD, or in RELEASE not yet emitted, on a non-pause entry: go to RELEASE, emit the break, then go directly to IDLE without GAP.
REQ-031 inj_abort in any other state: go directly to IDLE.
REQ-032 inj_abort flushes the queue in the same cycle; an inj_wr in that cycle is discarded.
REQ-033 inj_busy is high from the cycle after an accepted write until the FSM returns to IDLE with the queue empty.

Reset
REQ-034 On reset: FSM=IDLE, queue empty, counter=0, key_strobe=0, key_pressed=0, key_extended=0, key_code=8'h00, inj_full=0, inj_busy=0.
REQ-035 Reset mid-injection emits no break event; the key matrix is cleared by its own reset.
REQ-036 Reset has priority over all inputs, including inj_wr and hk_strobe in the same cycle.

Verification
REQ-037 Host passthrough: hk_strobe with code 8'h1c, pressed=1, FSM idle -> key_strobe high the next cycle with code 8'h1c, pressed=1, extended=0.
REQ-038 Single injection (HOLD=4, GAP=3): write 9'h01c -> make 8'h1c, break exactly 5 cycles later, inj_busy low after the 3 GAP cycles.
REQ-039 Full queue (DEPTH=4): write 5 entries back-to-back -> inj_full high after the 4th; the 5th is dropped; exactly 4 make/break pairs are produced in order.
REQ-040 Collision: hk_strobe in the injected-make cycle -> host event on the output first, injected make the following cycle, both single strobes.
REQ-041 Abort in HOLD for code 9'h175 -> one break with extended=1, code 8'h75; queue empty; inj_busy low within 2 cycles.
REQ-042 Pause entry 9'h000 between 'a' and 'b' -> no events for HOLD+GAP cycles between the 'a' break and the 'b' make, plus GAP cycles.

Source files
------------

// File: rtl/key_inject_arb.sv
// Merges host keyboard events with a queued stream of injected key presses.
// Host events always pass through in one cycle; injected keys are timed press/hold/release/gap.
module key_inject_arb #(
    parameter logic [15:0] HOLD_CYCLES = 16'd50000,
    parameter logic [15:0] GAP_CYCLES  = 16'd50000,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       hk_strobe,
    input  logic       hk_pressed,
    input  logic       hk_extended,
    input  logic [7:0] hk_code,
    input  logic       inj_wr,
    input  logic [8:0] inj_data,
    input  logic       inj_abort,
    output logic       inj_full,
    output logic       inj_busy,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic       key_extended,
    output logic [7:0] key_code
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] HOLD_LAST = (HOLD_CYCLES == 16'd0) ? 16'd0 : HOLD_CYCLES - 16'd1;
    localparam logic [15:0] GAP_LAST  = (GAP_CYCLES == 16'd0) ? 16'd0 : GAP_CYCLES - 16'd1;

    typedef enum logic [2:0] {S_IDLE, S_PRESS, S_HOLD, S_RELEASE, S_GAP} state_t;

    state_t        state, state_n;
    logic [15:0]   cnt, cnt_n;
    logic          quick, quick_n;
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_n;
    logic [8:0]    cur;
    logic          pop, push, emit, emit_press, is_pause;

    assign is_pause = (cur == 9'h000);

    // A full queue still accepts a write when the head is popped in the same cycle.
    always_comb begin
        pop  = (state == S_IDLE) && (count != '0) && !inj_abort;
        push = inj_wr && !inj_abort && ((count != DEPTH_C) || pop);
        if (inj_abort)
            count_n = '0;
        else
            count_n = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk_sys) begin
        if (push)
            mem[wr_ptr] <= inj_data;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            cur    <= 9'h000;
        end else begin
            count <= count_n;
            if (inj_abort) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    cur    <= mem[rd_ptr];
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 16'd0;
            quick <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            quick <= quick_n;
        end
    end

    // quick marks an aborted entry whose break is still owed; it skips GAP.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        quick_n    = quick;
        emit       = 1'b0;
        emit_press = 1'b0;
        case (state)
            S_IDLE: begin
                quick_n = 1'b0;
                if (pop) state_n = S_PRESS;
            end
            S_PRESS: begin
                if (inj_abort) begin
                    state_n = S_IDLE;
                end else if (is_pause) begin
                    state_n = S_HOLD;
                    cnt_n   = 16'd0;
                end else if (!hk_strobe) begin
                    emit       = 1'b1;
                    emit_press = 1'b1;
                    state_n    = S_HOLD;
                    cnt_n      = 16'd0;
                end
            end
            S_HOLD: begin
                if (inj_abort && !is_pause) begin
                    state_n = S_RELEASE;
                    quick_n = 1'b1;
                end else if (inj_abort) begin
                    state_n = S_IDLE;
                end else if (cnt == HOLD_LAST) begin
                    state_n = S_RELEASE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_RELEASE: begin
                if (is_pause) begin
                    state_n = inj_abort ? S_IDLE : S_GAP;
                    cnt_n   = 16'd0;
                end else if (!hk_strobe) begin
                    emit    = 1'b1;
                    state_n = (inj_abort || quick) ? S_IDLE : S_GAP;
                    cnt_n   = 16'd0;
                end else if (inj_abort) begin
                    quick_n = 1'b1;
                end
            end
            S_GAP: begin
                if (inj_abort || (cnt == GAP_LAST))
                    state_n = S_IDLE;
                else
                    cnt_n = cnt + 16'd1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            key_strobe   <= 1'b0;
            key_pressed  <= 1'b0;
            key_extended <= 1'b0;
            key_code     <= 8'h00;
            inj_full     <= 1'b0;
            inj_busy     <= 1'b0;
        end else begin
            key_strobe <= hk_strobe || emit;
            if (hk_strobe) begin
                key_pressed  <= hk_pressed;
                key_extended <= hk_extended;
                key_code     <= hk_code;
            end else if (emit) begin
                key_pressed  <= emit_press;
                key_extended <= cur[8];
                key_code     <= cur[7:0];
            end
            inj_full <= (count_n == DEPTH_C);
            inj_busy <= (count_n != '0) || (state_n != S_IDLE);
        end
    end
endmodule

// File: tb/tb_key_inject_arb.sv
// Directed and randomized checks of key_inject_arb against a timestamp-based event model.
// The model schedules each injected action by the cycle at which it becomes due.
module tb_key_inject_arb;
    localparam logic [15:0] H = 16'd4;
    localparam logic [15:0] G = 16'd3;
    localparam int          D = 4;
    localparam int          HE = (H == 16'd0) ? 1 : int'(H);
    localparam int          GE = (G == 16'd0) ? 1 : int'(G);

    logic       clk_sys = 1'b0;
    logic       reset, hk_strobe, hk_pressed, hk_extended, inj_wr, inj_abort;
    logic [7:0] hk_code;
    logic [8:0] inj_data;
    logic       inj_full, inj_busy, key_strobe, key_pressed, key_extended;
    logic [7:0] key_code;

    key_inject_arb #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .FIFO_DEPTH(D)) dut (
        .clk_sys(clk_sys), .reset(reset), .hk_strobe(hk_strobe), .hk_pressed(hk_pressed),
        .hk_extended(hk_extended), .hk_code(hk_code), .inj_wr(inj_wr), .inj_data(inj_data),
        .inj_abort(inj_abort), .inj_full(inj_full), .inj_busy(inj_busy), .key_strobe(key_strobe),
        .key_pressed(key_pressed), .key_extended(key_extended), .key_code(key_code)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model: pending queue, entry in flight, and the cycle its next action becomes due.
    logic [8:0] exp_q[$];
    bit         m_act, m_quick;
    int         m_step;   // 0 make owed, 1 break owed, 2 gap until m_due
    int         m_due;
    logic [8:0] m_cur;
    logic       m_strobe, m_pr, m_ex, m_full, m_busy;
    logic [7:0] m_code;

    int         ev_t[$];
    logic [9:0] ev_v[$];
    int         busy_fall;
    logic       prev_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int   n;
        bit   idle_now, emit;
        logic pr;
        n = cyc; emit = 0; pr = 0;
        if (reset) begin
            exp_q.delete();
            m_act = 0; m_quick = 0; m_strobe = 0; m_pr = 0; m_ex = 0; m_code = 8'h00;
            m_full = 0; m_busy = 0;
            return;
        end
        if (m_act && m_step == 2 && n >= m_due) m_act = 0;
        idle_now = !m_act;
        if (inj_abort) begin
            exp_q.delete();
            if (m_act && m_step == 1 && m_cur != 9'h000) begin
                m_quick = 1;
                if (n < m_due) m_due = n + 1;
            end else begin
                m_act = 0;
            end
        end
        if (m_act) begin
            if (m_step == 0) begin
                if (m_cur == 9'h000) begin
                    m_step = 1; m_due = n + 1 + HE;
                end else if (!hk_strobe) begin
                    emit = 1; pr = 1; m_step = 1; m_due = n + 1 + HE;
                end
            end else if (m_step == 1 && n >= m_due) begin
                if (m_cur == 9'h000) begin
                    m_step = 2; m_due = n + 1 + GE;
                end else if (!hk_strobe) begin
                    emit = 1; pr = 0;
                    if (m_quick) m_act = 0;
                    else begin m_step = 2; m_due = n + 1 + GE; end
                end
            end
        end
        m_strobe = hk_strobe || emit;
        if (hk_strobe) begin
            m_pr = hk_pressed; m_ex = hk_extended; m_code = hk_code;
        end else if (emit) begin
            m_pr = pr; m_ex = m_cur[8]; m_code = m_cur[7:0];
        end
        if (idle_now && !inj_abort && exp_q.size() > 0) begin
            m_cur = exp_q.pop_front(); m_act = 1; m_step = 0; m_quick = 0;
        end
        if (inj_wr && !inj_abort && exp_q.size() < D) exp_q.push_back(inj_data);
        m_full = (exp_q.size() == D);
        m_busy = (exp_q.size() > 0) || (m_act && !(m_step == 2 && n + 1 >= m_due));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_sys);
        #1;
        check("outputs", {19'd0, key_strobe, key_pressed, key_extended, key_code, inj_full, inj_busy},
              {19'd0, m_strobe, m_pr, m_ex, m_code, m_full, m_busy});
        if (key_strobe) begin
            ev_t.push_back(cyc);
            ev_v.push_back({key_pressed, key_extended, key_code});
        end
        if (prev_busy && !inj_busy) busy_fall = cyc;
        prev_busy = inj_busy;
        cyc++;
    endtask

    task automatic quiet();
        reset = 0; hk_strobe = 0; hk_pressed = 0; hk_extended = 0; hk_code = 8'h00;
        inj_wr = 0; inj_data = 9'h000; inj_abort = 0;
    endtask

    task automatic run(input int k);
        quiet();
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic wr(input logic [8:0] d);
        quiet(); inj_wr = 1; inj_data = d; tick(); quiet();
    endtask

    task automatic clear_log();
        ev_t.delete(); ev_v.delete(); busy_fall = -1;
    endtask

    initial begin
        int w, a, n_ev;
        quiet();
        reset = 1; inj_wr = 1; inj_data = 9'h055; hk_strobe = 1; hk_code = 8'h66;
        tick(); tick();
        check("reset_strobe", {31'd0, key_strobe}, 32'd0);
        check("reset_code", {24'd0, key_code}, 32'd0);
        check("reset_busy", {30'd0, inj_full, inj_busy}, 32'd0);
        run(2);

        // Host passthrough while idle.
        clear_log();
        quiet(); hk_strobe = 1; hk_pressed = 1; hk_code = 8'h1c; w = cyc; tick(); quiet();
        check("host_pass_cnt", ev_t.size(), 1);
        check("host_pass_time", ev_t[0] - w, 0);
        check("host_pass_val", {22'd0, ev_v[0]}, {22'd0, 2'b10, 8'h1c});
        run(2);

        // Single injection: break HOLD+1 cycles after make, busy drops after GAP.
        clear_log();
        w = cyc; wr(9'h01c); run(15);
        check("single_cnt", ev_t.size(), 2);
        check("single_make_t", ev_t[0] - w, 2);
        check("single_make_v", {22'd0, ev_v[0]}, {22'd0, 2'b10, 8'h1c});
        check("single_break_dt", ev_t[1] - ev_t[0], HE + 1);
        check("single_break_v", {22'd0, ev_v[1]}, {22'd0, 2'b00, 8'h1c});
        check("single_busy_fall", busy_fall - ev_t[1], GE);

        // Collision on the injected make cycle.
        clear_log();
        w = cyc; wr(9'h023); run(1);
        quiet(); hk_strobe = 1; hk_pressed = 0; hk_extended = 1; hk_code = 8'h5a; tick();
        run(15);
        check("coll_cnt", ev_t.size(), 3);
        check("coll_host_v", {22'd0, ev_v[0]}, {22'd0, 2'b01, 8'h5a});
        check("coll_make_dt", ev_t[1] - ev_t[0], 1);
        check("coll_make_v", {22'd0, ev_v[1]}, {22'd0, 2'b10, 8'h23});

        // Full queue: a pause entry keeps the FSM busy while five entries arrive.
        clear_log();
        wr(9'h000); run(2);
        for (int i = 0; i < 5; i++) begin
            wr(9'h041 + 9'(i));
            if (i == 3) check("full_after_4th", {31'd0, inj_full}, 32'd1);
        end
        check("full_after_5th", {31'd0, inj_full}, 32'd1);
        run(70);
        check("full_ev_cnt", ev_t.size(), 8);
        n_ev = ev_v.size();
        for (int i = 0; i < n_ev && i < 8; i++)
            check("full_order", {22'd0, ev_v[i]}, {22'd0, (i % 2 == 0), 1'b0, 8'h41 + 8'(i / 2)});

        // Abort during HOLD: one break, queue flushed, busy gone within 2 cycles.
        clear_log();
        wr(9'h175); wr(9'h011); run(2);
        quiet(); inj_abort = 1; a = cyc; tick();
        run(20);
        check("abort_cnt", ev_t.size(), 2);
        check("abort_break_v", {22'd0, ev_v[1]}, {22'd0, 2'b01, 8'h75});
        check("abort_busy_fall", (busy_fall - a <= 2 && busy_fall >= a) ? 1 : 0, 1);
        check("abort_idle", {31'd0, inj_busy}, 32'd0);

        // Pause entry between 'a' and 'b' adds one full silent entry period.
        clear_log();
        wr(9'h01c); wr(9'h000); wr(9'h032); run(40);
        check("pause_cnt", ev_t.size(), 4);
        check("pause_gap", ev_t[2] - ev_t[1], HE + 2 * GE + 5);
        check("pause_b_v", {22'd0, ev_v[2]}, {22'd0, 2'b10, 8'h32});

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            quiet();
            hk_strobe   = ($urandom_range(0, 7) == 0);
            hk_pressed  = 1'($urandom);
            hk_extended = 1'($urandom);
            hk_code     = 8'($urandom);
            inj_wr      = ($urandom_range(0, 5) == 0);
            inj_data    = ($urandom_range(0, 5) == 0) ? 9'h000 : 9'($urandom);
            inj_abort   = ($urandom_range(0, 60) == 0);
            reset       = ($urandom_range(0, 500) == 0);
            tick();
        end
        run(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
